counter_up60: RTL and testbench
===============================

# counter_up60

Two-digit BCD seconds up-counter, 00 to 59, with synchronous parallel load, active-low count enable and active-low ripple-carry output. It is the count-up counterpart of the timer's count-down seconds chain: it serves the stopwatch path and drives a downstream minutes stage through `rco_L`. Loaded values above 59 still count up, to 99, before wrapping to 00.

## Interface
- `TENS_MAX`, default 5: tens digit at which the nominal wrap occurs (59 → 00).
- `ONES_MAX`, default 9: ones digit terminal value.
- `clk` input, 1: single clock, rising-edge.
- `rst` input, 1: asynchronous, active-low reset.
- `enablen` input, 1: active-low count enable.
- `load` input, 1: active-high synchronous load; has priority over counting.
- `in_ones` input, 4: BCD ones digit to load.
- `in_tens` input, 4: BCD tens digit to load.
- `count_ones` output, 4: current ones digit (registered).
- `count_tens` output, 4: current tens digit (registered).
- `rco_L` output, 1: active-low ripple carry out; low in the cycle before the wrap to 00.

## Operation
- Priority, evaluated at each rising `clk`: `rst` low (asynchronous), then `load`, then count (`enablen` low), then hold.
- Load: `count_ones <= in_ones`, `count_tens <= in_tens`, independent of `enablen`. Any 4-bit value is accepted.
- Count, ones digit:
  - If ones ≥ `ONES_MAX`, ones → 0 and a tens increment is issued.
  - Otherwise ones → ones+1.
  - A loaded value of A–F therefore behaves like 9.
- Count, tens digit (only when a tens increment is issued):
  - Tens < `TENS_MAX`: tens+1.
  - Tens = `TENS_MAX`: tens → 0 (59 → 00).
  - `TENS_MAX` < tens < 9: tens+1 (e.g. 69 → 70).
  - Tens ≥ 9: tens → 0 (99 → 00; A–F → 0).
- Terminal count: ones ≥ `ONES_MAX` and (tens = `TENS_MAX` or tens ≥ 9).
- `rco_L` = 0 when `enablen` = 0, `load` = 0 and the count is terminal; otherwise 1.
- `rco_L` is combinational from the registered count and the inputs. It is glitch-free relative to the clock edge only.
- Hold: with `enablen` high and `load` low, the count is unchanged and `rco_L` = 1.

## Timing
- Reset values: `count_ones` = 0, `count_tens` = 0, `rco_L` = 1. Applied immediately on `rst` falling, held while low.
- Reset released mid-count: first count occurs on the first rising edge with `rst` high.
- Load latency: 1 clock. The new value is visible after the edge where `load` = 1.
- Count latency: 1 clock per increment.
- `rco_L` is low during the cycle holding 59 (or 99, or terminal invalid). The edge ending that cycle produces 00, so a downstream stage using the same `clk` increments on that same edge.
- Simultaneous `load` and terminal count: load wins, `rco_L` = 1, no carry.
- Simultaneous `rst` low and `load`: reset wins.

## Configuration
- Macro: `COUNTER_UP60_SATURATE_EN`.
- Defined:
  - At terminal count with `enablen` low, the counter holds instead of wrapping (stops at 59 or 99).
  - `rco_L` is still driven low while at terminal with `enablen` low.
  - Only `load` or `rst` leaves the terminal value.
- Undefined: wrap behaviour as in Operation.

## Structure
- Shared timer package holds:
  - BCD digit width constant (4).
  - Constants `BCD_NINE`, `BCD_ZERO`.
  - Default `TENS_MAX` and `ONES_MAX` values, so the up and down counters share them.
- Sub-module `bcd_digit_up` (one instance per digit): ports for clock, reset, enable, load, load value, max, carry in; outputs digit and carry.
- `counter_up60` instantiates two `bcd_digit_up`, chains the ones carry into the tens enable, and adds the 9→0 override for tens above `TENS_MAX` plus the `rco_L` logic.

## Test plan
- Reset: assert `rst` low mid-count at 37 → outputs 00 immediately, `rco_L` = 1; release, 3 enabled clocks → 03.
- Nominal wrap: load 57, `enablen` low, 3 clocks → 58, 59, 00; `rco_L` = 0 only during the 59 cycle.
- Over-range: load 97, count → 98, 99, 00; `rco_L` low only at 99. Load 65 → 66 … 69, 70.
- Invalid BCD: load ones = B, tens = 2, one clock → 30. Load ones = C, tens = F → terminal, `rco_L` = 0, next clock 00.
- Priority: at 59 with `load` = 1, `in` = 12, `enablen` = 0 → `rco_L` = 1, next value 12. `enablen` high at 59 → holds, `rco_L` = 1.
- With `COUNTER_UP60_SATURATE_EN`: load 58, 4 enabled clocks → 59, 59, 59, 59 with `rco_L` = 0 throughout the hold; then load 00 → 00.

Source files
------------

// File: rtl/counter_up60_pkg.sv
// counter_up60_pkg: timer constants shared by the BCD up and down counters
package counter_up60_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] bcd_t;
  localparam bcd_t BCD_NINE = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;
  localparam int TENS_MAX_DEF = 5;
  localparam int ONES_MAX_DEF = 9;
endpackage

// File: rtl/counter_up60_if.sv
// counter_up60_if: control, load and count/carry signals of the seconds up-counter
interface counter_up60_if;
  import counter_up60_pkg::*;
  logic enablen;
  logic load;
  bcd_t in_ones;
  bcd_t in_tens;
  bcd_t count_ones;
  bcd_t count_tens;
  logic rco_L;
  modport slave (input enablen, load, in_ones, in_tens, output count_ones, count_tens, rco_L);
  modport master (output enablen, load, in_ones, in_tens, input count_ones, count_tens, rco_L);
endinterface

// File: rtl/counter_up60_bcd_digit_up.sv
// bcd_digit_up: one BCD digit counting up to i_max then wrapping, with load and carry out
module bcd_digit_up
  import counter_up60_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_load,
  input  bcd_t i_load_val,
  input  bcd_t i_max,
  input  logic i_cin,
  output bcd_t o_digit,
  output logic o_carry
);
  bcd_t r_digit;
  logic w_top;
  assign w_top = r_digit >= i_max;
  assign o_carry = i_cin && w_top;
  assign o_digit = r_digit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_digit <= BCD_ZERO;
    else if (i_load) r_digit <= i_load_val;
    else if (i_en && i_cin) r_digit <= w_top ? BCD_ZERO : r_digit + 4'd1;
endmodule

// File: rtl/counter_up60.sv
// counter_up60: BCD seconds up-counter 00..59 (over-range to 99) with load and active-low ripple carry
// COUNTER_UP60_SATURATE_EN: hold at the terminal count instead of wrapping
module counter_up60
  import counter_up60_pkg::*;
#(
  parameter int TENS_MAX = TENS_MAX_DEF,
  parameter int ONES_MAX = ONES_MAX_DEF
) (
  input logic clk,
  input logic rst,
  counter_up60_if.slave bus
);
  bcd_t w_ones;
  bcd_t w_tens;
  bcd_t w_tens_max;
  logic w_ones_c;
  logic w_term;
  logic w_cnt;
  // tens above TENS_MAX keep counting to 9 before wrapping
  assign w_tens_max = (w_tens > 4'(TENS_MAX)) ? BCD_NINE : 4'(TENS_MAX);
`ifdef COUNTER_UP60_SATURATE_EN
  assign w_cnt = !bus.enablen && !w_term;
`else
  assign w_cnt = !bus.enablen;
`endif
  bcd_digit_up u_ones (
    .clk(clk), .rst(rst), .i_en(w_cnt), .i_load(bus.load), .i_load_val(bus.in_ones),
    .i_max(4'(ONES_MAX)), .i_cin(1'b1), .o_digit(w_ones), .o_carry(w_ones_c)
  );
  bcd_digit_up u_tens (
    .clk(clk), .rst(rst), .i_en(w_cnt), .i_load(bus.load), .i_load_val(bus.in_tens),
    .i_max(w_tens_max), .i_cin(w_ones_c), .o_digit(w_tens), .o_carry(w_term)
  );
  assign bus.count_ones = w_ones;
  assign bus.count_tens = w_tens;
  assign bus.rco_L = !(!bus.enablen && !bus.load && w_term);
endmodule

// File: tb/tb_counter_up60.sv
// tb_counter_up60: directed vectors with a queued scoreboard checked by a separate monitor
module tb_counter_up60;
  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic rco;
    int id;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int idx = 0;
  exp_t sb[$];
  counter_up60_if bus();
  counter_up60 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic r, ld, en_n, input logic [3:0] it, io, et, eo, input logic erco);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.load = ld;
    bus.enablen = en_n;
    bus.in_tens = it;
    bus.in_ones = io;
    e.t = et;
    e.o = eo;
    e.rco = erco;
    e.id = idx;
    sb.push_back(e);
    idx++;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (bus.count_tens !== e.t || bus.count_ones !== e.o || bus.rco_L !== e.rco) begin
        n_err++;
        $display("FAIL step%0d: got %h%h rco_L=%b, want %h%h rco_L=%b",
                 e.id, bus.count_tens, bus.count_ones, bus.rco_L, e.t, e.o, e.rco);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.load = 1'b0;
    bus.enablen = 1'b1;
    bus.in_tens = 4'h0;
    bus.in_ones = 4'h0;
    step(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    step(1, 1, 1, 4'h3, 4'h5, 4'h0, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h3, 4'h5, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h3, 4'h6, 1);
    step(1, 0, 1, 4'h0, 4'h0, 4'h3, 4'h7, 1);
    step(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    step(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h3, 1);
`ifdef COUNTER_UP60_SATURATE_EN
    step(1, 1, 1, 4'h5, 4'h8, 4'h0, 4'h3, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h8, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h9, 0);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h9, 0);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h9, 0);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h9, 0);
    step(1, 1, 0, 4'h0, 4'h0, 4'h5, 4'h9, 1);
    step(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
`else
    step(1, 1, 1, 4'h5, 4'h7, 4'h0, 4'h3, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h7, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h8, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h9, 0);
    step(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    step(1, 1, 1, 4'h9, 4'h7, 4'h0, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h9, 4'h7, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h9, 4'h8, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h9, 4'h9, 0);
    step(1, 1, 1, 4'h6, 4'h5, 4'h0, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h6, 4'h5, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h6, 4'h6, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h6, 4'h7, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h6, 4'h8, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h6, 4'h9, 1);
    step(1, 1, 1, 4'h2, 4'hB, 4'h7, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h2, 4'hB, 1);
    step(1, 1, 1, 4'hF, 4'hC, 4'h3, 4'h0, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'hF, 4'hC, 0);
    step(1, 1, 1, 4'h5, 4'h9, 4'h0, 4'h0, 1);
    step(1, 1, 0, 4'h1, 4'h2, 4'h5, 4'h9, 1);
    step(1, 1, 1, 4'h5, 4'h9, 4'h1, 4'h2, 1);
    step(1, 0, 1, 4'h0, 4'h0, 4'h5, 4'h9, 1);
    step(1, 0, 1, 4'h0, 4'h0, 4'h5, 4'h9, 1);
    step(1, 0, 0, 4'h0, 4'h0, 4'h5, 4'h9, 0);
    step(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
`endif
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
